fifo_drain: RTL and testbench



---
 rtl/fifo_drain.sv | 102 ++++++++++
 tb/tb_fifo_drain.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - two-entry registered skid buffer draining an upstream FIFO onto a valid/ready stream
// Optional feature macro: FIFO_DRAIN_CNT_EN (saturating delivered-word counter on drained_cnt).

module fifo_drain #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_pop,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drained_cnt
);

   logic [1:0]       occ_q, occ_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             deq;

   // Pop looks only at registered occupancy so out_ready never reaches the FIFO combinationally.
   assign fifo_pop  = rst & ~flush & ~fifo_empty & (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = head_q;
   assign occupancy = occ_q;
   assign deq       = out_valid & out_ready & ~flush;

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         unique case (occ_q)
            2'd0: begin
               if (fifo_pop) begin
                  head_d = fifo_data;
                  occ_d  = 2'd1;
               end
            end
            2'd1: begin
               if (fifo_pop && !deq) begin
                  tail_d = fifo_data;
                  occ_d  = 2'd2;
               end else if (!fifo_pop && deq) begin
                  occ_d = 2'd0;
               end else if (fifo_pop && deq) begin
                  head_d = fifo_data;
               end
            end
            2'd2: begin
               if (deq) begin
                  head_d = tail_q;
                  occ_d  = 2'd1;
               end
            end
            default: occ_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

`ifdef FIFO_DRAIN_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating; flush deliberately leaves the count alone.
   always_comb begin
      cnt_d = cnt_q;
      if (deq && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign drained_cnt = cnt_q;
`else
   assign drained_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - randomized check of fifo_drain against a queue-based reference model
// Counter expectations follow FIFO_DRAIN_CNT_EN when it is defined for the build.

module tb_fifo_drain;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_pop;
   logic             flush;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] drained_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_m = 0;
   logic [WIDTH-1:0] src[$];
   logic [WIDTH-1:0] bufm[$];

   fifo_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_pop    (fifo_pop),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .occupancy   (occupancy),
      .drained_cnt (drained_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_cnt();
`ifdef FIFO_DRAIN_CNT_EN
      return cnt_m;
`else
      return 0;
`endif
   endfunction

   // One clock of stimulus: inputs set after the falling edge, outputs checked
   // 1 ns later, then the model advances as of the following rising edge.
   task automatic step(input logic fl, input logic rdy);
      logic ep;
      logic dq;
      @(negedge clk);
      flush      = fl;
      out_ready  = rdy;
      fifo_empty = (src.size() == 0);
      fifo_data  = fifo_empty ? WIDTH'($urandom) : src[0];
      #1;
      ep = rst && !fl && !fifo_empty && (bufm.size() < 2);
      dq = (bufm.size() != 0) && rdy && !fl;
      check("pop", 32'(fifo_pop), 32'(ep));
      check("valid", 32'(out_valid), 32'(bufm.size() != 0));
      check("occ", 32'(occupancy), 32'(bufm.size()));
      if (bufm.size() != 0)
         check("data", 32'(out_data), 32'(bufm[0]));
      check("cnt", 32'(drained_cnt), 32'(exp_cnt()));
      if (fl) begin
         bufm.delete();
      end else begin
         if (dq) begin
            void'(bufm.pop_front());
            if (cnt_m < CNT_MAX) cnt_m++;
         end
         if (ep) bufm.push_back(src.pop_front());
      end
   endtask

   task automatic check_reset_state();
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_cnt", 32'(drained_cnt), 32'd0);
   endtask

   initial begin
      rst        = 1'b0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      src.push_back(8'hA5);
      fifo_empty = 1'b0;
      fifo_data  = 8'hA5;
      #12;
      check_reset_state();
      src.delete();
      @(posedge clk);
      #1 rst = 1'b1;

      // Streaming three words with the consumer always ready.
      src.push_back(8'h11);
      src.push_back(8'h22);
      src.push_back(8'h33);
      repeat (6) step(1'b0, 1'b1);

      // Back-pressure: only two pops then stall, then drain in order.
      for (int i = 0; i < 4; i++) src.push_back(WIDTH'(8'h40 + i));
      repeat (5) step(1'b0, 1'b0);
      check("bp_occ", 32'(occupancy), 32'd2);
      check("bp_left", 32'(src.size()), 32'd2);
      repeat (7) step(1'b0, 1'b1);

      // Flush while full with the FIFO still non-empty.
      for (int i = 0; i < 4; i++) src.push_back(WIDTH'(8'h80 + i));
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b1);

      // Randomized traffic with occasional flushes and bursty ready.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 45 && src.size() < 8)
            src.push_back(WIDTH'($urandom));
         step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < ((c / 300) % 2 ? 80 : 30));
      end

      // Asynchronous reset in mid-operation drops buffered words.
      for (int i = 0; i < 3; i++) src.push_back(WIDTH'(8'hC0 + i));
      repeat (3) step(1'b0, 1'b0);
      @(negedge clk);
      fifo_empty = 1'b0;
      fifo_data  = src[0];
      #2 rst = 1'b0;
      #1;
      check_reset_state();
      bufm.delete();
      cnt_m = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) step(1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
